// File: rtl/cnu_minsum.sv
// Offset min-sum check-node unit: accumulates one row of shifted VTC beats per lane,
// then replays one CTV beat per column with the offset-corrected min magnitude.
module cnu_minsum #(
    parameter int data_w  = 8,
    parameter int D       = 5,
    parameter int MAX_DEG = 8,
    parameter int IDX_W   = 3,
    parameter int OFFSET  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [data_w*D-1:0] in_data,
    input  logic                in_null,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [data_w*D-1:0] out_data,
    output logic                out_null,
    output logic [IDX_W-1:0]    out_col,
    output logic                out_last,
    output logic                err
);
    localparam int MW = data_w - 1;
    typedef logic [MW-1:0] mag_t;
    localparam mag_t             MAG_ALL1 = {MW{1'b1}};
    localparam logic [IDX_W-1:0] COL_MAX  = IDX_W'(MAX_DEG - 1);

    typedef enum logic {ACC, OUT} state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_col;
    logic [IDX_W-1:0] r_deg_m1;   // degree minus one, so a full MAX_DEG row fits IDX_W
    logic             r_err;

    mag_t             r_min1 [D];
    mag_t             r_min2 [D];
    logic [IDX_W-1:0] r_idx1 [D];
    logic [D-1:0]     r_sgn;

    logic [D-1:0]       r_sign_mem [MAX_DEG];
    logic [MAX_DEG-1:0] r_null_mem;

    logic         w_in_fire;
    logic         w_out_fire;
    logic         w_row_end;
    logic         w_row_done;
    logic [D-1:0] w_in_sgn;
    mag_t         w_in_mag [D];

    function automatic mag_t sub_offset(input mag_t m);
        if (int'(m) > OFFSET)
            return m - mag_t'(OFFSET);
        return '0;
    endfunction

    // A zero magnitude never carries a negative sign.
    function automatic logic [data_w-1:0] ctv_word(input logic s, input mag_t m);
        return {s & (|m), m};
    endfunction

    assign in_ready   = (r_state == ACC);
    assign out_valid  = (r_state == OUT);
    assign err        = r_err;

    assign w_in_fire  = in_ready && in_valid;
    assign w_out_fire = out_valid && out_ready;
    assign w_row_end  = in_last || (r_col == COL_MAX);
    assign w_row_done = (r_col == r_deg_m1);

    always_comb begin
        w_in_sgn = '0;
        w_in_mag = '{default: '0};
        for (int k = 0; k < D; k++) begin
            w_in_sgn[k] = in_data[data_w*k + MW];
            w_in_mag[k] = in_data[data_w*k +: MW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ACC;
            r_col    <= '0;
            r_deg_m1 <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (in_valid) begin
                        if (w_row_end) begin
                            r_deg_m1 <= r_col;
                            r_col    <= '0;
                            r_state  <= OUT;
                            if (!in_last)
                                r_err <= 1'b1;
                        end else begin
                            r_col <= r_col + IDX_W'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (w_row_done) begin
                            r_col   <= '0;
                            r_state <= ACC;
                        end else begin
                            r_col <= r_col + IDX_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Accumulators re-initialise on reset and on the edge that retires the last output beat.
    always_ff @(posedge clk) begin
        if (rst || (w_out_fire && w_row_done)) begin
            for (int k = 0; k < D; k++) begin
                r_min1[k] <= MAG_ALL1;
                r_min2[k] <= MAG_ALL1;
                r_idx1[k] <= '0;
            end
            r_sgn <= '0;
        end else if (w_in_fire && !in_null) begin
            for (int k = 0; k < D; k++) begin
                if (w_in_mag[k] < r_min1[k]) begin
                    r_min2[k] <= r_min1[k];
                    r_min1[k] <= w_in_mag[k];
                    r_idx1[k] <= r_col;
                end else if (w_in_mag[k] < r_min2[k]) begin
                    r_min2[k] <= w_in_mag[k];
                end
            end
            r_sgn <= r_sgn ^ w_in_sgn;
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_null_mem[r_col] <= in_null;
            if (!in_null)
                r_sign_mem[r_col] <= w_in_sgn;
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < D; k++) begin
            out_data[data_w*k +: data_w] =
                ctv_word(r_sgn[k] ^ r_sign_mem[r_col][k],
                         sub_offset((r_col == r_idx1[k]) ? r_min2[k] : r_min1[k]));
        end
        if (!out_valid || r_null_mem[r_col])
            out_data = '0;
    end

    assign out_null = out_valid && r_null_mem[r_col];
    assign out_col  = out_valid ? r_col : '0;
    assign out_last = out_valid && w_row_done;

endmodule

// File: doc/cnu_minsum.md
# cnu_minsum

Per-lane offset min-sum check-node unit for the layered LDPC decoder. It sits directly downstream of the cyclic-shift stage and consumes its shifted variable-to-check vector (`c`), one base-matrix column per beat, across one row. It then replays one check-to-variable vector per column for the return shift (`ctv` input of the shift stage). Each of the D lanes is an independent check node.

## Interface

**Parameters**
- `data_w`, 8: message width, sign-magnitude. Bit `data_w-1` is the sign (1 = negative); the low `data_w-1` bits are the magnitude.
- `D`, 5: lanes (expansion factor); same value as the shift stage.
- `MAX_DEG`, 8: maximum columns per row.
- `IDX_W`, 3: column index width, equal to clog2(`MAX_DEG`).
- `OFFSET`, 1: magnitude offset subtracted from every output magnitude.

**Ports**
- `clk`  in  1: clock.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `in_valid`  in  1: input beat valid.
- `in_ready`  out  1: unit accepts an input beat.
- `in_data`  in  `data_w*D`: shifted VTC vector. Lane k occupies bits [`data_w*k` +: `data_w`].
- `in_null`  in  1: column is a null block (shift = all ones). `in_data` is ignored.
- `in_last`  in  1: last column of the row.
- `out_valid`  out  1: output beat valid.
- `out_ready`  in  1: downstream accepts the output beat.
- `out_data`  out  `data_w*D`: CTV vector, same lane packing as `in_data`.
- `out_null`  out  1: output column is a null block.
- `out_col`  out  `IDX_W`: column index of the output beat, 0-based.
- `out_last`  out  1: final output beat of the row.
- `err`  out  1: sticky row-overflow flag; cleared only by `rst`.

## Operation

**States**
- `ACC`: the reset state. `in_ready`=1. An input beat is accepted when `in_valid`&&`in_ready`.
- `OUT`: `out_valid`=1. An output beat is accepted when `out_valid`&&`out_ready`.

**Per-lane accumulation (ACC state)**
- State per lane: `min1`, `min2`, `idx1`, `sgn`. On entry to ACC: `min1`=`min2`=all-ones magnitude, `idx1`=0, `sgn`=0. Column counter `col`=0.
- Each accepted beat writes its null bit into `null_mem[col]`. If the beat is non-null, it also writes each lane's sign into `sign_mem[col][k]`, then per lane with magnitude m:
  - if m < `min1`: `min2`←`min1`, `min1`←m, `idx1`←`col`;
  - else if m < `min2`: `min2`←m.
  - Strict compare, so on a tie the earlier column keeps `idx1`.
- Every accepted non-null beat also updates `sgn`←`sgn`^sign.
- Null beats occupy a column slot but leave `min1`, `min2`, `idx1` and `sgn` untouched.
- `col` increments on each accepted beat.
- The row ends on an accepted beat with `in_last`=1, or when `col`==`MAX_DEG`-1. In the second case, without `in_last`, `err` is set and the beat is treated as last.
- The row end records `deg`=`col`+1 and moves to OUT with `col`=0.

**Replay (OUT state)**
- For column j, lane k:
  - mag = (j==`idx1`) ? `min2` : `min1`;
  - mag' = (mag > `OFFSET`) ? mag-`OFFSET` : 0;
  - sign = `sgn` ^ `sign_mem[j][k]`;
  - output = {sign, mag'}.
- If mag' = 0, the output sign bit is forced to 0, so no negative zero is emitted.
- For a null column: `out_null`=1 and `out_data`=0.
- `out_col`=j; `out_last`=(j==`deg`-1).
- Each accepted output beat increments j. Acceptance of the `out_last` beat returns the unit to ACC, with the accumulators re-initialised in that same edge.

**Boundary conditions**
- Row with a single non-null column: its output magnitude uses `min2` = all-ones, i.e. max-`OFFSET`.
- All-null row: every output beat is null.
- `out_ready` low: the output beat is held stable; j does not advance.
- `in_*` inputs are ignored in OUT.
- `rst` mid-row: the row is discarded; the unit returns to ACC with everything cleared.

## Timing

- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_null`=0, `out_col`=0, `out_last`=0, `err`=0.
- Throughput: one input beat per cycle in ACC; one output beat per cycle in OUT when `out_ready`=1.
- Latency: the last input is accepted at edge N and `out_valid`=1 in cycle N+1, i.e. one cycle.
- The final output beat is accepted at edge M and `in_ready`=1 in cycle M+1. A row of degree d with `out_ready` held high therefore occupies 2d cycles.
- Output fields are driven from registered state only: `min1`, `min2`, `idx1`, `sgn`, `sign_mem`, `null_mem`, j. They are 0 while `out_valid`=0.
- `in_ready` and `out_valid` are never high together.

## Test plan

- **Basic row.** D=2, `OFFSET`=1. Lane 0 gets +5, −3, +7; lane 1 gets −2, −2, +4; third beat has `in_last`=1.
  Required: lane 0 outputs −2, +4, −2; lane 1 outputs −1, −1, +1; `out_last` on j=2; `in_ready` back in the following cycle.
- **Null column.** Beats +6, null, +4 with `in_last`.
  Required: beat 0 = +3; beat 1 `out_null`=1 with data 0; beat 2 = +5; `sgn` unaffected by the null beat.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles mid-replay.
  Required: `out_data`, `out_col` and `out_null` stable; j unchanged; no beat lost or duplicated.
- **Overflow.** 8 beats with no `in_last`.
  Required: beat 7 ends the row; `err`=1 and stays 1 until `rst`; 8 output beats, `out_last` on `out_col`=7.
- **Degree-1 and zero-magnitude cases.** Single beat −0 with `in_last`: output +126 (127−1), sign positive.
  Separately, two beats of magnitude 1: both outputs 0 with sign bit 0.
- **Mid-row reset.** Assert `rst` after 2 of 4 beats.
  Required: `in_ready`=1 and `out_valid`=0 next cycle; a fresh 3-beat row then produces correct results with no leftover minima.
